// File: rtl/mux_scan_capture.sv
// mux_scan_capture
//   Drives the three select lines {W0,W1,W2} of an 8-to-1 mux stage and
//   captures its output F into an 8-bit snapshot, one enabled channel at a
//   time in ascending order. The result is offered on a valid/ready handshake.
//
//   Optional feature macro: MUX_SCAN_SETTLE_EN
//     When defined, every enabled channel spends one extra cycle in a SETTLE
//     state with the selects stable before F is sampled. This gives a slow
//     mux tree two cycles per channel instead of one.

module mux_scan_capture (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] mask,
  input  logic       F,
  output logic       W0,
  output logic       W1,
  output logic       W2,
  output logic       busy,
  output logic [7:0] sample,
  output logic       valid,
  input  logic       out_ready
);

  // Channel index driven on the selects while no scan is running.
  localparam logic [2:0] IDLE_SEL = 3'b000;

`ifdef MUX_SCAN_SETTLE_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t     state_q, state_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] sample_q, sample_d;
  logic [2:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       valid_q, valid_d;

  // Lowest enabled channel whose index is >= from. Returns {found, index};
  // from may be 8 (one past the last channel), which always yields "none",
  // so the scan never wraps around.
  function automatic logic [3:0] findFrom(input logic [7:0] m, input logic [3:0] from);
    logic [3:0] res;
    res = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) begin
        res = {1'b1, 3'(i)};
      end
    end
    return res;
  endfunction

  // First channel of a new scan, taken straight from the live mask input.
  logic [3:0] firstHit;
  // Next channel after the one currently selected, from the latched mask.
  logic [3:0] nextHit;

  // Channel search for the start of a scan and for each advance step.
  always_comb begin
    firstHit = findFrom(mask, 4'd0);
    nextHit  = findFrom(mask_q, {1'b0, sel_q} + 4'd1);
  end

  // Next-state logic: sequences the selects, folds F into the snapshot and
  // runs the output handshake. Everything holds unless a branch says otherwise.
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    sample_d = sample_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    valid_d  = valid_q;

    case (state_q)
      IDLE: begin
        sel_d   = IDLE_SEL;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        if (start) begin
          mask_d   = mask;
          sample_d = 8'h00;
          busy_d   = 1'b1;
          if (firstHit[3]) begin
            sel_d = firstHit[2:0];
`ifdef MUX_SCAN_SETTLE_EN
            state_d = SETTLE;
`else
            state_d = SCAN;
`endif
          end else begin
            // Nothing enabled: the all-zero snapshot is ready at once.
            state_d = DONE;
            valid_d = 1'b1;
          end
        end
      end

`ifdef MUX_SCAN_SETTLE_EN
      SETTLE: begin
        state_d = SCAN;
      end
`endif

      SCAN: begin
        sample_d[sel_q] = F;
        if (nextHit[3]) begin
          sel_d = nextHit[2:0];
`ifdef MUX_SCAN_SETTLE_EN
          state_d = SETTLE;
`else
          state_d = SCAN;
`endif
        end else begin
          sel_d   = IDLE_SEL;
          state_d = DONE;
          valid_d = 1'b1;
        end
      end

      DONE: begin
        // start is deliberately ignored here, including on the handshake
        // edge itself; the snapshot stays put until the next accepted start.
        if (out_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
        sel_d   = IDLE_SEL;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial snapshot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mask_q   <= 8'h00;
      sample_q <= 8'h00;
      sel_q    <= IDLE_SEL;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      sample_q <= sample_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  // W0 carries weight 4 (pair group), W2 weight 1 (within the pair).
  assign W0     = sel_q[2];
  assign W1     = sel_q[1];
  assign W2     = sel_q[0];
  assign busy   = busy_q;
  assign valid  = valid_q;
  assign sample = sample_q;

endmodule
